digital_tube_scan_ctrl: RTL and testbench
=========================================

Name: digital_tube_scan_ctrl

Overview:
Memory-mapped scan controller for the board's three seven-segment groups: tube0 (4 digits, sel0), tube1 (4 digits, sel1) and tube2 (1 digit, sel2).
- The CPU bridge writes a 32-bit hex value, an auxiliary nibble and a control word.
- The block time-multiplexes the digits with a prescaled scan counter.
- Displayed data is double-buffered and updates only at frame boundaries, so the display never shows a torn value.
- Sits beside the UART, DIP-switch and LED devices on the peripheral bus.

Parameters:
SCAN_DIV, 25000, clk cycles per digit slot (>=2; benches use 4)
CNT_W, 16, prescaler width; must satisfy 2^CNT_W > SCAN_DIV

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
addr  in  2  word select: 0=DATA, 1=AUX, 2=CTRL, 3=reserved
we  in  1  write strobe, sampled at posedge clk
be  in  4  byte enables for the write
wdata  in  32  write data
rdata  out  32  combinational read of the addressed register (reserved reads 0)
digital_tube0  out  8  segments of the tube0 digit being scanned, active-low, bit7 = dp
digital_tube1  out  8  segments of the tube1 digit being scanned, active-low
digital_tube2  out  8  tube2 segments, active-low
sel0  out  4  tube0 digit select, one-hot, active-high
sel1  out  4  tube1 digit select, one-hot, active-high
sel2  out  1  tube2 select, active-high
frame_tick  out  1  one-cycle pulse when the shadow registers reload

Behaviour:
Clock and reset:
- One clock domain (clk).
- reset is asynchronous and active-high; it clears all flops immediately, independent of clk.

Reset values:
- DATA=0, AUX=0, CTRL=0, shadows=0, prescaler=0, idx=0.
- digital_tube0/1/2 = 8'hff, sel0 = sel1 = 0, sel2 = 0, frame_tick = 0.

Register writes:
- Byte-granular under be; visible on rdata the next cycle.
- AUX keeps bits [3:0] only; other bits read 0.
- CTRL bit0 = EN, bits [9:1] = per-digit blank mask: digits 0-3 of tube0, then digits 0-3 of tube1, then the tube2 digit. Other CTRL bits read 0.

Prescaler:
- Counts 0..SCAN_DIV-1 while EN=1.
- On reaching SCAN_DIV-1 it wraps to 0 and advances idx (2-bit, 0..3, wraps 3->0).

Shadow reload:
- When idx wraps 3->0, or on the first cycle after EN rises, shadow DATA/AUX/mask are loaded from the live registers.
- frame_tick pulses in that same cycle.
- A write in the same cycle as a reload: the shadow takes the pre-write value; the new value appears next frame.

Outputs when EN=1 (registered, one cycle after idx/shadow update):
- sel0 = sel1 = 1<<idx; sel2 = 1.
- digital_tube0 = ~seg(shadow_DATA[4*idx+3:4*idx]).
- digital_tube1 = ~seg(shadow_DATA[16+4*idx+3:16+4*idx]).
- digital_tube2 = ~seg(shadow_AUX).
- If a digit's mask bit is set, its segments = 8'hff; sel stays asserted.
- dp is always off (bit7 = 1).

EN behaviour:
- EN=0: prescaler and idx are held at 0, all selects are 0, segments are 8'hff, no frame_tick.
- Clearing EN mid-frame blanks on the next cycle.
- Re-enabling restarts at idx=0 with a fresh shadow load.

Hex glyphs:
- Standard 0-F glyphs; b, d lowercase.
- Segment order g..a in bits [6:0].

Decomposition:
- Package disp_pkg: register offsets (DATA/AUX/CTRL), CTRL field positions, EN bit, blank-mask width 9, SEG_OFF = 8'hff.
- One sub-module, hex7seg: combinational 4-bit to 7-bit decoder producing positive-logic segment outputs. Instantiate it three times.
- Scan counter, shadow registers and bus logic stay in the top level.

Test Plan:
1. Reset: assert reset asynchronously mid-cycle -> all outputs take their reset values immediately (segments 8'hff, selects 0, frame_tick 0); rdata at addr 0 reads 0.
2. Basic scan, SCAN_DIV=4: write DATA=32'h8765_4321, AUX=4'hA, CTRL=1 -> frame_tick pulses.
   - sel0 steps 0001, 0010, 0100, 1000 every 4 cycles.
   - digital_tube0 shows ~seg(1), ~seg(2), ~seg(3), ~seg(4); digital_tube1 shows ~seg(5)..~seg(8).
   - digital_tube2 = ~seg(A) = 8'h88; sel2 = 1.
3. Tear-free update: write DATA=32'hFFFF_FFFF while idx=2 -> the remaining slots of that frame still show the old digits; the new digits appear only after the next frame_tick.
4. Byte enables and masking: write be=4'b0010, wdata=32'h0000_AB00 over DATA=0 -> rdata = 32'h0000_AB00; CTRL=32'h0000_0003 -> tube0 digit0 reads 8'hff while sel0 = 0001.
5. Disable mid-frame: clear EN at idx=1 -> the next cycle has all selects 0 and segments 8'hff; set EN again -> frame_tick pulses and the scan restarts at sel0 = 0001.
6. Reset mid-frame: assert reset at idx=3 -> idx=0 and all registers 0; after release with EN=0 the display stays blank.

Source files
------------

// File: rtl/digital_tube_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller.
// Contents: register word offsets, CTRL field positions, blank-mask width,
// the all-off segment pattern and a helper for active-low segment drive.
package disp_pkg;

  typedef enum logic [1:0] {
    REG_DATA = 2'd0,
    REG_AUX  = 2'd1,
    REG_CTRL = 2'd2,
    REG_RSVD = 2'd3
  } reg_addr_e;

  localparam int CTRL_EN_BIT = 0;
  localparam int MASK_LSB    = 1;
  localparam int MASK_W      = 9;
  localparam int CTRL_W      = MASK_LSB + MASK_W;
  localparam int AUX_W       = 4;

  localparam logic [7:0] SEG_OFF = 8'hff;

  // Converts positive-logic g..a segments to the active-low pad pattern.
  // The decimal point (bit7) is never lit.
  function automatic logic [7:0] seg_drive(input logic [6:0] seg, input logic blank);
    return blank ? SEG_OFF : {1'b1, ~seg};
  endfunction

endpackage

// File: rtl/digital_tube_scan_ctrl_if.sv
// Peripheral-bus port bundle of the scan controller.
//   addr  : word select (DATA / AUX / CTRL / reserved)
//   we    : write strobe
//   be    : byte enables
//   wdata : write data
//   rdata : combinational read data of the addressed word
interface digital_tube_scan_ctrl_if;
  logic [1:0]  addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, we, be, wdata, input rdata);
  modport slave  (input addr, we, be, wdata, output rdata);
endinterface

// File: rtl/digital_tube_scan_ctrl_hex7seg.sv
// Hex nibble to seven-segment decoder, positive logic.
//   hex : nibble to display
//   seg : segments g..a in bits [6:0], 1 = lit
module hex7seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    case (hex)
      4'h0: seg = 7'h3f;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5b;
      4'h3: seg = 7'h4f;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6d;
      4'h6: seg = 7'h7d;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7f;
      4'h9: seg = 7'h6f;
      4'ha: seg = 7'h77;
      4'hb: seg = 7'h7c;
      4'hc: seg = 7'h39;
      4'hd: seg = 7'h5e;
      4'he: seg = 7'h79;
      4'hf: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/digital_tube_scan_ctrl.sv
// Memory-mapped scan controller for three seven-segment groups.
//   clk, reset         : system clock, asynchronous active-high reset
//   bus                : register access (DATA, AUX, CTRL)
//   digital_tube0/1    : active-low segments of the scanned tube0/tube1 digit
//   digital_tube2      : active-low segments of the single tube2 digit
//   sel0/sel1          : one-hot digit selects, active-high
//   sel2               : tube2 select, active-high
//   frame_tick         : one-cycle pulse when the display shadows reload
module digital_tube_scan_ctrl
  import disp_pkg::*;
#(
  parameter int SCAN_DIV = 25000,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  digital_tube_scan_ctrl_if.slave  bus,
  output logic [7:0]               digital_tube0,
  output logic [7:0]               digital_tube1,
  output logic [7:0]               digital_tube2,
  output logic [3:0]               sel0,
  output logic [3:0]               sel1,
  output logic                     sel2,
  output logic                     frame_tick
);

  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(SCAN_DIV - 1);

  logic [31:0]       data_q;
  logic [AUX_W-1:0]  aux_q;
  logic [CTRL_W-1:0] ctrl_q;

  logic [31:0]       shadow_data;
  logic [AUX_W-1:0]  shadow_aux;
  logic [MASK_W-1:0] shadow_mask;

  logic [CNT_W-1:0]  presc;
  logic [1:0]        idx;
  logic              en_d;

  logic              en;
  logic              slot_end;
  logic              reload;
  logic              show;
  logic [3:0]        nib0;
  logic [3:0]        nib1;
  logic [6:0]        seg0;
  logic [6:0]        seg1;
  logic [6:0]        seg2;

  assign en       = ctrl_q[CTRL_EN_BIT];
  assign slot_end = (presc == PRESC_LAST);
  // Reload on the first enabled cycle and whenever idx wraps 3->0.
  assign reload   = en && (!en_d || (slot_end && idx == 2'd3));
  // The first enabled cycle is still loading the shadows, so keep it blank.
  assign show     = en && en_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      aux_q  <= '0;
      ctrl_q <= '0;
    end else if (bus.we) begin
      case (reg_addr_e'(bus.addr))
        REG_DATA: begin
          for (int b = 0; b < 4; b++) begin
            if (bus.be[b]) data_q[8*b +: 8] <= bus.wdata[8*b +: 8];
          end
        end
        REG_AUX: begin
          if (bus.be[0]) aux_q <= bus.wdata[AUX_W-1:0];
        end
        REG_CTRL: begin
          if (bus.be[0]) ctrl_q[7:0] <= bus.wdata[7:0];
          if (bus.be[1]) ctrl_q[CTRL_W-1:8] <= bus.wdata[CTRL_W-1:8];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.rdata = '0;
    case (reg_addr_e'(bus.addr))
      REG_DATA: bus.rdata = data_q;
      REG_AUX:  bus.rdata = 32'(aux_q);
      REG_CTRL: bus.rdata = 32'(ctrl_q);
      default:  bus.rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
      en_d  <= 1'b0;
    end else begin
      en_d <= en;
      if (!en) begin
        presc <= '0;
        idx   <= '0;
      end else if (slot_end) begin
        presc <= '0;
        idx   <= idx + 2'd1;
      end else begin
        presc <= presc + CNT_W'(1);
      end
    end
  end

  // Shadows sample the pre-write register values, so a same-cycle write
  // lands in the following frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_data <= '0;
      shadow_aux  <= '0;
      shadow_mask <= '0;
    end else if (reload) begin
      shadow_data <= data_q;
      shadow_aux  <= aux_q;
      shadow_mask <= ctrl_q[MASK_LSB +: MASK_W];
    end
  end

  assign nib0 = shadow_data[{idx, 2'b00} +: 4];
  assign nib1 = shadow_data[{1'b1, idx, 2'b00} +: 4];

  hex7seg u_dec0 (.hex(nib0),       .seg(seg0));
  hex7seg u_dec1 (.hex(nib1),       .seg(seg1));
  hex7seg u_dec2 (.hex(shadow_aux), .seg(seg2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digital_tube0 <= SEG_OFF;
      digital_tube1 <= SEG_OFF;
      digital_tube2 <= SEG_OFF;
      sel0          <= '0;
      sel1          <= '0;
      sel2          <= 1'b0;
      frame_tick    <= 1'b0;
    end else begin
      frame_tick <= reload;
      if (show) begin
        digital_tube0 <= seg_drive(seg0, shadow_mask[idx]);
        digital_tube1 <= seg_drive(seg1, shadow_mask[{1'b1, idx}]);
        digital_tube2 <= seg_drive(seg2, shadow_mask[MASK_W-1]);
        sel0          <= 4'b0001 << idx;
        sel1          <= 4'b0001 << idx;
        sel2          <= 1'b1;
      end else begin
        digital_tube0 <= SEG_OFF;
        digital_tube1 <= SEG_OFF;
        digital_tube2 <= SEG_OFF;
        sel0          <= '0;
        sel1          <= '0;
        sel2          <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_digital_tube_scan_ctrl.sv
module tb_digital_tube_scan_ctrl;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  digital_tube_scan_ctrl_if bus();

  logic [7:0] t0, t1, t2;
  logic [3:0] s0, s1;
  logic       s2, ft;

  digital_tube_scan_ctrl #(.SCAN_DIV(D), .CNT_W(16)) dut (
    .clk          (clk),
    .reset        (rst),
    .bus          (bus),
    .digital_tube0(t0),
    .digital_tube1(t1),
    .digital_tube2(t2),
    .sel0         (s0),
    .sel1         (s1),
    .sel2         (s2),
    .frame_tick   (ft)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3f;  4'h1: return 7'h06;  4'h2: return 7'h5b;  4'h3: return 7'h4f;
      4'h4: return 7'h66;  4'h5: return 7'h6d;  4'h6: return 7'h7d;  4'h7: return 7'h07;
      4'h8: return 7'h7f;  4'h9: return 7'h6f;  4'ha: return 7'h77;  4'hb: return 7'h7c;
      4'hc: return 7'h39;  4'hd: return 7'h5e;  4'he: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic logic [7:0] pad(input logic [6:0] g, input logic blank);
    return blank ? 8'hff : {1'b1, ~g};
  endfunction

  // Reference model: n counts clock edges since the edge that set EN.
  // Output after edge n shows slot ((n-1)/D)%4 once n>=2; shadows reload
  // at edge 1 and at every multiple of 4*D.
  int          m_n;
  logic [31:0] m_data, s_data;
  logic [3:0]  m_aux,  s_aux;
  logic [9:0]  m_ctrl;
  logic [8:0]  s_mask;
  logic [7:0]  e_t0, e_t1, e_t2;
  logic [3:0]  e_sel;
  logic        e_s2, e_ft;

  int          n_nx, slot_nx;
  logic        rel_nx, act_nx;
  logic [31:0] d_nx;
  logic [3:0]  a_nx;
  logic [9:0]  c_nx;
  logic [7:0]  t0_nx, t1_nx, t2_nx;
  logic [3:0]  sel_nx;

  always_comb begin
    n_nx    = m_ctrl[0] ? m_n + 1 : 0;
    rel_nx  = m_ctrl[0] && (n_nx == 1 || (n_nx % (4 * D)) == 0);
    act_nx  = (n_nx >= 2);
    slot_nx = act_nx ? ((n_nx - 1) / D) % 4 : 0;
    t0_nx   = 8'hff;
    t1_nx   = 8'hff;
    t2_nx   = 8'hff;
    sel_nx  = 4'b0000;
    if (act_nx) begin
      t0_nx  = pad(glyph(s_data[4*slot_nx +: 4]), s_mask[slot_nx]);
      t1_nx  = pad(glyph(s_data[16 + 4*slot_nx +: 4]), s_mask[4 + slot_nx]);
      t2_nx  = pad(glyph(s_aux), s_mask[8]);
      sel_nx = 4'(1 << slot_nx);
    end
    d_nx = m_data;
    a_nx = m_aux;
    c_nx = m_ctrl;
    if (bus.we) begin
      case (bus.addr)
        2'd0: for (int b = 0; b < 4; b++) if (bus.be[b]) d_nx[8*b +: 8] = bus.wdata[8*b +: 8];
        2'd1: if (bus.be[0]) a_nx = bus.wdata[3:0];
        2'd2: begin
          if (bus.be[0]) c_nx[7:0] = bus.wdata[7:0];
          if (bus.be[1]) c_nx[9:8] = bus.wdata[9:8];
        end
        default: ;
      endcase
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n <= 0; m_data <= '0; m_aux <= '0; m_ctrl <= '0;
      s_data <= '0; s_aux <= '0; s_mask <= '0;
      e_t0 <= 8'hff; e_t1 <= 8'hff; e_t2 <= 8'hff;
      e_sel <= '0; e_s2 <= 1'b0; e_ft <= 1'b0;
    end else begin
      m_n    <= n_nx;
      m_data <= d_nx;
      m_aux  <= a_nx;
      m_ctrl <= c_nx;
      if (rel_nx) begin
        s_data <= m_data;
        s_aux  <= m_aux;
        s_mask <= m_ctrl[9:1];
      end
      e_t0  <= t0_nx;
      e_t1  <= t1_nx;
      e_t2  <= t2_nx;
      e_sel <= sel_nx;
      e_s2  <= act_nx;
      e_ft  <= rel_nx;
    end
  end

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return m_data;
      2'd1:    return {28'd0, m_aux};
      2'd2:    return {22'd0, m_ctrl};
      default: return 32'd0;
    endcase
  endfunction

  // Every cycle, late in the cycle, compare everything against the model.
  always begin
    @(posedge clk);
    #8;
    check("tube0", t0, e_t0);
    check("tube1", t1, e_t1);
    check("tube2", t2, e_t2);
    check("sel0", s0, e_sel);
    check("sel1", s1, e_sel);
    check("sel2", s2, e_s2);
    check("frame_tick", ft, e_ft);
    check("rdata", bus.rdata, model_read(bus.addr));
  end

  task automatic bus_write(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
    @(negedge clk);
    bus.addr = a; bus.be = be; bus.wdata = d; bus.we = 1'b1;
    @(negedge clk);
    bus.we = 1'b0; bus.be = 4'h0;
  endtask

  task automatic wait_ft(input string tag);
    for (int k = 0; k < 200 && ft !== 1'b1; k++) @(negedge clk);
    check(tag, ft, 1'b1);
  endtask

  task automatic wait_sel0(input logic [3:0] v, input string tag);
    for (int k = 0; k < 200 && s0 !== v; k++) @(negedge clk);
    check(tag, s0, v);
  endtask

  initial begin
    bus.addr = 2'd0; bus.we = 1'b0; bus.be = 4'h0; bus.wdata = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tube0", t0, 8'hff);
    check("rst_sel0", s0, 4'h0);
    check("rst_rdata", bus.rdata, 32'h0);
    rst = 1'b0;

    // Basic scan
    bus_write(2'd0, 4'hf, 32'h8765_4321);
    bus_write(2'd1, 4'hf, 32'h0000_000a);
    bus_write(2'd2, 4'hf, 32'h0000_0001);
    wait_ft("en_frame_tick");
    wait_sel0(4'b0001, "scan_slot0");
    check("slot0_tube0", t0, 8'hf9);
    check("slot0_tube1", t1, 8'h92);
    check("slot0_tube2", t2, 8'h88);
    check("slot0_sel2", s2, 1'b1);
    wait_sel0(4'b0010, "scan_slot1");
    check("slot1_tube0", t0, 8'ha4);
    check("slot1_tube1", t1, 8'h82);
    wait_sel0(4'b0100, "scan_slot2");

    // Tear-free update during slot 2
    bus_write(2'd0, 4'hf, 32'hffff_ffff);
    wait_sel0(4'b1000, "scan_slot3");
    check("slot3_old_tube0", t0, 8'h99);
    check("slot3_old_tube1", t1, 8'h80);
    wait_ft("wrap_frame_tick");
    wait_sel0(4'b0001, "new_slot0");
    check("new_tube0", t0, 8'h8e);
    check("new_tube1", t1, 8'h8e);

    // Byte enables and masking
    bus_write(2'd0, 4'hf, 32'h0000_0000);
    bus_write(2'd0, 4'b0010, 32'h55aa_ab77);
    bus.addr = 2'd0;
    #1;
    check("be_rdata", bus.rdata, 32'h0000_ab00);
    bus_write(2'd2, 4'hf, 32'h0000_0003);
    wait_ft("mask_frame_tick");
    wait_sel0(4'b0001, "mask_slot0");
    check("mask_tube0", t0, 8'hff);
    check("mask_tube1", t1, 8'hc0);

    // Randomized traffic, EN mostly kept on
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      bus.addr  = 2'($urandom_range(0, 3));
      bus.we    = ($urandom_range(0, 9) == 0);
      bus.be    = 4'($urandom);
      bus.wdata = $urandom;
      if (bus.addr == 2'd2 && $urandom_range(0, 4) != 0) begin
        bus.wdata[0] = 1'b1;
        bus.be[0]    = 1'b1;
      end
    end
    @(negedge clk);
    bus.we = 1'b0;

    // Disable mid-frame, then re-enable
    bus_write(2'd2, 4'hf, 32'h0000_0001);
    wait_ft("dis_frame_tick");
    wait_sel0(4'b0010, "dis_slot1");
    bus_write(2'd2, 4'h1, 32'h0000_0000);
    @(negedge clk);
    check("dis_sel0", s0, 4'h0);
    check("dis_tube0", t0, 8'hff);
    check("dis_sel2", s2, 1'b0);
    bus_write(2'd2, 4'h1, 32'h0000_0001);
    wait_ft("reen_frame_tick");
    for (int k = 0; k < 50 && s0 === 4'h0; k++) @(negedge clk);
    check("reen_first_sel0", s0, 4'b0001);

    // Reset mid-frame at slot 3
    wait_sel0(4'b1000, "rst_slot3");
    @(negedge clk);
    bus.addr = 2'd2;
    #2 rst = 1'b1;
    #1;
    check("midrst_tube0", t0, 8'hff);
    check("midrst_tube2", t2, 8'hff);
    check("midrst_sel0", s0, 4'h0);
    check("midrst_sel2", s2, 1'b0);
    check("midrst_ft", ft, 1'b0);
    check("midrst_ctrl", bus.rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_sel0", s0, 4'h0);
    check("post_rst_tube1", t1, 8'hff);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
